spi_tx_engine: RTL and testbench

SPI_TX_ENGINE -- requirements
Module: spi_tx_engine

---
 rtl/spi_tx_engine.sv | 249 ++++++++++++++++++++++++
 tb/tb_spi_tx_engine.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_engine.sv
// SPI transmit engine: buffers words and serialises them onto MOSI, one bit
// per external Shift_Sig strobe, with gapless reload between frames.
// Build option: define SPI_TX_ENGINE_FIFO_EN for a FIFO_DEPTH-entry TX FIFO;
// when it is undefined a single holding register buffers the next word.
module spi_tx_engine #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              Wr_En,
    input  logic [DATA_W-1:0] Wr_Data,
    input  logic              Lsb_First,
    input  logic              Shift_Sig,
    output logic              MOSI,
    output logic              Busy_Sig,
    output logic              Done_Sig,
    output logic              Full,
    output logic              Ovf_Sig
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Elaboration-time parameter sanity checks
    if (DATA_W < 2 || DATA_W > 32) begin : g_bad_data_w
        $error("spi_tx_engine: DATA_W must be within 2..32");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("spi_tx_engine: FIFO_DEPTH must be a power of two >= 2");
    end

    // Buffer <-> shifter handshake
    logic              w_buf_empty;
    logic [DATA_W-1:0] w_buf_head;
    logic              w_push_ok;
    logic              w_pop;

    // Frame engine state
    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_lsb;
    logic              w_lsb_nxt;
    logic              r_mosi;
    logic              w_mosi_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              w_load;

    // Next-state and datapath decode: load, shift, or frame completion
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_lsb_nxt   = r_lsb;
        w_mosi_nxt  = r_mosi;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Shift strobes are ignored here; only a buffered word starts a frame
                if (!w_buf_empty) begin
                    w_load = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (Shift_Sig) begin
                    if (r_cnt == '0) begin
                        w_done_nxt = 1'b1;
                        if (!w_buf_empty) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_busy_nxt  = 1'b0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_ONE;
                        if (r_lsb) begin
                            w_shift_nxt = r_shift >> 1;
                            w_mosi_nxt  = r_shift[1];
                        end else begin
                            w_shift_nxt = r_shift << 1;
                            w_mosi_nxt  = r_shift[DATA_W-2];
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // A load drives the first bit immediately and latches the bit order
        if (w_load) begin
            w_state_nxt = ST_SHIFT;
            w_shift_nxt = w_buf_head;
            w_lsb_nxt   = Lsb_First;
            w_mosi_nxt  = Lsb_First ? w_buf_head[0] : w_buf_head[DATA_W-1];
            w_cnt_nxt   = CNT_LAST;
            w_busy_nxt  = 1'b1;
        end
    end

    assign w_pop = w_load;

    // FSM state register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame control registers: counter, bit order, MOSI and status pulses
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_cnt  <= '0;
            r_lsb  <= 1'b0;
            r_mosi <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_lsb  <= w_lsb_nxt;
            r_mosi <= w_mosi_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Shift register holds pure data; its content is ignored until a load
    always_ff @(posedge CLK) begin
        r_shift <= w_shift_nxt;
    end

    assign MOSI     = r_mosi;
    assign Busy_Sig = r_busy;
    assign Done_Sig = r_done;

`ifdef SPI_TX_ENGINE_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [OCC_W-1:0]  r_occ;
    logic [OCC_W-1:0]  w_occ_nxt;
    logic              r_full;
    logic              r_ovf;

    // A push is refused while full, even if a pop frees a slot this cycle
    assign w_push_ok   = Wr_En && !r_full;
    assign w_buf_empty = (r_occ == '0);
    assign w_buf_head  = r_mem[r_rd_ptr];

    // Occupancy update: push+pop together leaves it unchanged
    always_comb begin
        w_occ_nxt = r_occ;
        case ({w_push_ok, w_pop})
            2'b10:   w_occ_nxt = r_occ + OCC_ONE;
            2'b01:   w_occ_nxt = r_occ - OCC_ONE;
            default: w_occ_nxt = r_occ;
        endcase
    end

    // FIFO storage write at the tail
    always_ff @(posedge CLK) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= Wr_Data;
        end
    end

    // FIFO pointers (wrap naturally), occupancy, registered Full and overflow pulse
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_full   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_occ  <= w_occ_nxt;
            r_full <= (w_occ_nxt == OCC_FULL);
            r_ovf  <= Wr_En && r_full;
        end
    end

    assign Full    = r_full;
    assign Ovf_Sig = r_ovf;
`else
    logic [DATA_W-1:0] r_hold_data;
    logic              r_hold_vld;
    logic              r_ovf;

    // The holding register counts as full whenever it carries a word
    assign w_push_ok   = Wr_En && !r_hold_vld;
    assign w_buf_empty = !r_hold_vld;
    assign w_buf_head  = r_hold_data;

    // Holding register data capture
    always_ff @(posedge CLK) begin
        if (w_push_ok) begin
            r_hold_data <= Wr_Data;
        end
    end

    // Holding register valid flag and overflow pulse
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_hold_vld <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_hold_vld <= 1'b1;
            end else if (w_pop) begin
                r_hold_vld <= 1'b0;
            end
            r_ovf <= Wr_En && r_hold_vld;
        end
    end

    assign Full    = r_hold_vld;
    assign Ovf_Sig = r_ovf;
`endif

endmodule

// File: tb/tb_spi_tx_engine.sv
// Testbench for spi_tx_engine: directed scenarios plus a randomized run
// against a queue-based reference model of the transmit behaviour.
module tb_spi_tx_engine;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
`ifdef SPI_TX_ENGINE_FIFO_EN
    localparam int CAP = DEPTH;
`else
    localparam int CAP = 1;
`endif

    logic          CLK       = 1'b0;
    logic          RSTn      = 1'b0;
    logic          Wr_En     = 1'b0;
    logic [DW-1:0] Wr_Data   = '0;
    logic          Lsb_First = 1'b0;
    logic          Shift_Sig = 1'b0;
    logic          MOSI, Busy_Sig, Done_Sig, Full, Ovf_Sig;

    logic          w_en16   = 1'b0;
    logic [15:0]   w_data16 = '0;
    logic          lsb16    = 1'b0;
    logic          shift16  = 1'b0;
    logic          mosi16, busy16, done16, full16, ovf16;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    spi_tx_engine #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) u_dut (
        .CLK(CLK), .RSTn(RSTn), .Wr_En(Wr_En), .Wr_Data(Wr_Data),
        .Lsb_First(Lsb_First), .Shift_Sig(Shift_Sig), .MOSI(MOSI),
        .Busy_Sig(Busy_Sig), .Done_Sig(Done_Sig), .Full(Full), .Ovf_Sig(Ovf_Sig)
    );

    spi_tx_engine #(.DATA_W(16), .FIFO_DEPTH(DEPTH)) u_dut16 (
        .CLK(CLK), .RSTn(RSTn), .Wr_En(w_en16), .Wr_Data(w_data16),
        .Lsb_First(lsb16), .Shift_Sig(shift16), .MOSI(mosi16),
        .Busy_Sig(busy16), .Done_Sig(done16), .Full(full16), .Ovf_Sig(ovf16)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic strobe();
        Shift_Sig = 1'b1;
        tick();
        Shift_Sig = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] d);
        Wr_En   = 1'b1;
        Wr_Data = d;
        tick();
        Wr_En   = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        Wr_En = 1'b1; Wr_Data = 8'h77;
        tick();
        Wr_En = 1'b0;
        n_vec++;
        if ({MOSI, Busy_Sig, Done_Sig, Full, Ovf_Sig} !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_outputs got %b exp 00000", {MOSI, Busy_Sig, Done_Sig, Full, Ovf_Sig});
        end
        n_vec++;
        if ({mosi16, busy16, done16, full16, ovf16} !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_outputs16 got %b exp 00000", {mosi16, busy16, done16, full16, ovf16});
        end
        RSTn = 1'b1;
        tick();
        tick();
        n_vec++;
        if (Busy_Sig !== 1'b0) begin
            n_err++;
            $display("FAIL reset_push_ignored busy got %b exp 0", Busy_Sig);
        end
    endtask

    task automatic test_msb_first();
        logic [7:0] seq, got;
        seq = 8'b10100101;
        Lsb_First = 1'b0;
        push(8'hA5);
        tick();
        n_vec++;
        if (Busy_Sig !== 1'b1) begin
            n_err++;
            $display("FAIL msb_busy_on_load got %b exp 1", Busy_Sig);
        end
        for (int i = 0; i < 8; i++) begin
            got[7-i] = MOSI;
            strobe();
            if (i < 7) begin
                n_vec++;
                if ({Done_Sig, Busy_Sig} !== 2'b01) begin
                    n_err++;
                    $display("FAIL msb_mid_frame strobe %0d done/busy got %b exp 01", i, {Done_Sig, Busy_Sig});
                end
                repeat ($urandom_range(0, 2)) tick();
            end
        end
        n_vec++;
        if ({Done_Sig, Busy_Sig} !== 2'b10) begin
            n_err++;
            $display("FAIL msb_frame_end done/busy got %b exp 10", {Done_Sig, Busy_Sig});
        end
        n_vec++;
        if (got !== seq) begin
            n_err++;
            $display("FAIL msb_bits got %b exp %b", got, seq);
        end
        tick();
        n_vec++;
        if (Done_Sig !== 1'b0) begin
            n_err++;
            $display("FAIL msb_done_width got %b exp 0", Done_Sig);
        end
        strobe();
        tick();
        n_vec++;
        if ({MOSI, Busy_Sig, Done_Sig} !== 3'b100) begin
            n_err++;
            $display("FAIL idle_strobe_hold mosi/busy/done got %b exp 100", {MOSI, Busy_Sig, Done_Sig});
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] words [2];
        logic [7:0] seqs  [2];
        logic [7:0] got;
        words[0] = 8'hA5; seqs[0] = 8'b10100101;
        words[1] = 8'h3C; seqs[1] = 8'b00111100;
        for (int f = 0; f < 2; f++) begin
            Lsb_First = 1'b1;
            push(words[f]);
            tick();
            for (int i = 0; i < 8; i++) begin
                if (i == 2) Lsb_First = 1'b0;
                got[7-i] = MOSI;
                strobe();
            end
            n_vec++;
            if (got !== seqs[f]) begin
                n_err++;
                $display("FAIL lsb_bits word %h got %b exp %b", words[f], got, seqs[f]);
            end
            n_vec++;
            if ({Done_Sig, Busy_Sig} !== 2'b10) begin
                n_err++;
                $display("FAIL lsb_frame_end done/busy got %b exp 10", {Done_Sig, Busy_Sig});
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] got;
        int          dones;
        dones     = 0;
        Lsb_First = 1'b0;
        push(8'h3C);
        tick();
        push(8'hC3);
        for (int i = 0; i < 16; i++) begin
            got[15-i] = MOSI;
            strobe();
            if (Done_Sig === 1'b1) dones++;
            if (i == 7) begin
                n_vec++;
                if ({Done_Sig, Busy_Sig, MOSI} !== 3'b111) begin
                    n_err++;
                    $display("FAIL b2b_reload done/busy/mosi got %b exp 111", {Done_Sig, Busy_Sig, MOSI});
                end
            end
            if (i < 15) begin
                n_vec++;
                if (Busy_Sig !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_busy_gap strobe %0d got %b exp 1", i, Busy_Sig);
                end
                if ($urandom_range(0, 1) == 1) begin
                    tick();
                    n_vec++;
                    if ({Busy_Sig, Done_Sig} !== 2'b10) begin
                        n_err++;
                        $display("FAIL b2b_idle_gap busy/done got %b exp 10", {Busy_Sig, Done_Sig});
                    end
                end
            end
        end
        n_vec++;
        if ({Done_Sig, Busy_Sig} !== 2'b10) begin
            n_err++;
            $display("FAIL b2b_end done/busy got %b exp 10", {Done_Sig, Busy_Sig});
        end
        n_vec++;
        if (dones != 2) begin
            n_err++;
            $display("FAIL b2b_done_count got %0d exp 2", dones);
        end
        n_vec++;
        if (got !== 16'h3CC3) begin
            n_err++;
            $display("FAIL b2b_bits got %h exp 3cc3", got);
        end
        tick();
    endtask

    task automatic test_overflow();
        logic [7:0] w [6];
        logic [7:0] exp_tx [$];
        logic [5:0] efull, eovf;
        logic [7:0] got;
        w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33;
        w[3] = 8'h44; w[4] = 8'h55; w[5] = 8'h66;
`ifdef SPI_TX_ENGINE_FIFO_EN
        efull = 6'b110000;
        eovf  = 6'b100000;
        exp_tx = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
`else
        efull = 6'b111101;
        eovf  = 6'b111010;
        exp_tx = '{8'h11, 8'h33};
`endif
        Lsb_First = 1'b0;
        for (int k = 0; k < 6; k++) begin
            Wr_En   = 1'b1;
            Wr_Data = w[k];
            tick();
            n_vec++;
            if ({Full, Ovf_Sig} !== {efull[k], eovf[k]}) begin
                n_err++;
                $display("FAIL ovf_push %0d full/ovf got %b exp %b", k + 1, {Full, Ovf_Sig}, {efull[k], eovf[k]});
            end
        end
        Wr_En = 1'b0;
        tick();
        n_vec++;
        if (Ovf_Sig !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_pulse_width got %b exp 0", Ovf_Sig);
        end
        for (int f = 0; f < exp_tx.size(); f++) begin
            for (int i = 0; i < 8; i++) begin
                got[7-i] = MOSI;
                strobe();
            end
            n_vec++;
            if (got !== exp_tx[f]) begin
                n_err++;
                $display("FAIL ovf_drain frame %0d got %h exp %h", f, got, exp_tx[f]);
            end
        end
        n_vec++;
        if ({Busy_Sig, Full} !== 2'b00) begin
            n_err++;
            $display("FAIL ovf_dropped_word busy/full got %b exp 00", {Busy_Sig, Full});
        end
        tick();
    endtask

    task automatic test_reset_midframe();
        logic [7:0] got;
        Lsb_First = 1'b0;
        push(8'h5A);
        tick();
        push(8'h11);
        repeat (3) strobe();
        n_vec++;
        if ({MOSI, Busy_Sig} !== 2'b11) begin
            n_err++;
            $display("FAIL rst_pre mosi/busy got %b exp 11", {MOSI, Busy_Sig});
        end
        #2;
        RSTn = 1'b0;
        #1;
        n_vec++;
        if ({MOSI, Busy_Sig, Done_Sig, Full, Ovf_Sig} !== 5'b00000) begin
            n_err++;
            $display("FAIL rst_async got %b exp 00000", {MOSI, Busy_Sig, Done_Sig, Full, Ovf_Sig});
        end
        tick();
        tick();
        RSTn = 1'b1;
        tick();
        tick();
        n_vec++;
        if (Busy_Sig !== 1'b0) begin
            n_err++;
            $display("FAIL rst_discard busy got %b exp 0", Busy_Sig);
        end
        push(8'hFF);
        tick();
        for (int i = 0; i < 8; i++) begin
            got[7-i] = MOSI;
            strobe();
        end
        n_vec++;
        if ({got, Done_Sig, Busy_Sig} !== {8'hFF, 2'b10}) begin
            n_err++;
            $display("FAIL rst_fresh_frame bits/done/busy got %h/%b exp ff/10", got, {Done_Sig, Busy_Sig});
        end
        tick();
        tick();
        n_vec++;
        if (Busy_Sig !== 1'b0) begin
            n_err++;
            $display("FAIL rst_no_stale_frame busy got %b exp 0", Busy_Sig);
        end
    endtask

    task automatic test_wide();
        logic [15:0] got;
        w_en16   = 1'b1;
        w_data16 = 16'h8001;
        tick();
        w_en16 = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            got[15-i] = mosi16;
            shift16   = 1'b1;
            tick();
            shift16   = 1'b0;
            if (i < 15) begin
                n_vec++;
                if ({done16, busy16} !== 2'b01) begin
                    n_err++;
                    $display("FAIL wide_mid strobe %0d done/busy got %b exp 01", i, {done16, busy16});
                end
            end
        end
        n_vec++;
        if ({done16, busy16} !== 2'b10) begin
            n_err++;
            $display("FAIL wide_end done/busy got %b exp 10", {done16, busy16});
        end
        n_vec++;
        if (got !== 16'h8001) begin
            n_err++;
            $display("FAIL wide_bits got %h exp 8001", got);
        end
        tick();
    endtask

    function automatic logic bit_of(input logic [DW-1:0] w, input logic lsb, input int idx);
        int pos;
        pos = lsb ? idx : (DW - 1 - idx);
        return w[pos];
    endfunction

    task automatic test_random();
        logic [DW-1:0] q [$];
        logic [DW-1:0] m_word;
        logic          m_lsb, m_act, m_mosi;
        int            m_idx;
        logic          we, ss, lsb, full_prev, e_done, e_ovf, e_full, do_load;
        logic [DW-1:0] wd;
        logic [4:0]    expv, gotv;
        int            push_div;
        RSTn = 1'b0;
        tick();
        RSTn = 1'b1;
        m_act = 1'b0; m_mosi = 1'b0; m_idx = 0; m_word = '0; m_lsb = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            push_div = (cyc < 400) ? 12 : 4;
            we  = ($urandom_range(0, push_div - 1) == 0);
            wd  = DW'($urandom);
            lsb = 1'($urandom);
            ss  = ($urandom_range(0, 1) == 1);
            Wr_En = we; Wr_Data = wd; Lsb_First = lsb; Shift_Sig = ss;
            full_prev = (q.size() == CAP);
            e_ovf   = we && full_prev;
            e_done  = 1'b0;
            do_load = 1'b0;
            if (!m_act) begin
                do_load = (q.size() != 0);
            end else if (ss) begin
                if (m_idx == DW - 1) begin
                    e_done = 1'b1;
                    if (q.size() != 0) do_load = 1'b1;
                    else m_act = 1'b0;
                end else begin
                    m_idx++;
                    m_mosi = bit_of(m_word, m_lsb, m_idx);
                end
            end
            if (do_load) begin
                m_word = q.pop_front();
                m_lsb  = lsb;
                m_idx  = 0;
                m_act  = 1'b1;
                m_mosi = bit_of(m_word, m_lsb, 0);
            end
            if (we && !full_prev) q.push_back(wd);
            e_full = (q.size() == CAP);
            tick();
            expv = {m_mosi, m_act, e_done, e_full, e_ovf};
            gotv = {MOSI, Busy_Sig, Done_Sig, Full, Ovf_Sig};
            n_vec++;
            if (gotv !== expv) begin
                n_err++;
                $display("FAIL random cyc %0d mosi/busy/done/full/ovf got %b exp %b", cyc, gotv, expv);
            end
        end
        Wr_En = 1'b0; Shift_Sig = 1'b0; Lsb_First = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        test_wide();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
